// File: rtl/bist_response_analyzer_if.sv
// bist_response_analyzer_if: pattern/response stream in, session results out
interface bist_response_analyzer_if #(parameter int SIG_WIDTH = 8);
  logic start;
  logic pat_valid;
  logic [2:0] pat;
  logic [1:0] resp;
  logic [SIG_WIDTH-1:0] golden_sig;
  logic busy;
  logic done;
  logic pass;
  logic [7:0] err_cnt;
  logic [2:0] first_fail;
  logic fail_seen;
  logic [7:0] fail_map;
  logic [SIG_WIDTH-1:0] signature;
  modport master (
    output start, pat_valid, pat, resp, golden_sig,
    input busy, done, pass, err_cnt, first_fail, fail_seen, fail_map, signature
  );
  modport slave (
    input start, pat_valid, pat, resp, golden_sig,
    output busy, done, pass, err_cnt, first_fail, fail_seen, fail_map, signature
  );
endinterface

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: full-adder golden check plus MISR compaction of BIST responses
module bist_response_analyzer #(
  parameter int NUM_PATTERNS = 8,
  parameter int SIG_WIDTH = 8,
  parameter logic [SIG_WIDTH-1:0] SIG_SEED = 8'h00
) (
  input logic clk,
  input logic rst_n,
  bist_response_analyzer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [SIG_WIDTH-1:0] POLY = SIG_WIDTH'('h1D);
  logic [1:0] state;
  logic [7:0] cnt;
  logic [1:0] expected;
  logic mismatch;
  logic accept;
  logic last;
  logic restart;
  logic [SIG_WIDTH-1:0] sig_next;
  logic [7:0] err_next;
  always_comb begin
    expected = {^bus.pat, (bus.pat[2] & bus.pat[1]) | (bus.pat[2] & bus.pat[0]) | (bus.pat[1] & bus.pat[0])};
    mismatch = bus.resp != expected;
    accept = (state == RUN) && bus.pat_valid;
    last = accept && (cnt == 8'(NUM_PATTERNS - 1));
    restart = bus.start && (state != RUN);
    sig_next = {bus.signature[SIG_WIDTH-2:0], 1'b0} ^ (bus.signature[SIG_WIDTH-1] ? POLY : '0) ^ SIG_WIDTH'(bus.resp);
    err_next = bus.err_cnt + {7'd0, mismatch && (bus.err_cnt != 8'hFF)};
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.pass <= 1'b0;
      bus.err_cnt <= '0;
      bus.first_fail <= '0;
      bus.fail_seen <= 1'b0;
      bus.fail_map <= '0;
      bus.signature <= SIG_SEED;
    end else if (restart) begin
      state <= RUN;
      cnt <= '0;
      bus.pass <= 1'b0;
      bus.err_cnt <= '0;
      bus.first_fail <= '0;
      bus.fail_seen <= 1'b0;
      bus.fail_map <= '0;
      bus.signature <= SIG_SEED;
    end else if (accept) begin
      cnt <= cnt + 8'd1;
      bus.signature <= sig_next;
      bus.err_cnt <= err_next;
      if (mismatch) begin
        bus.fail_map[bus.pat] <= 1'b1;
        if (!bus.fail_seen) begin
          bus.first_fail <= bus.pat;
          bus.fail_seen <= 1'b1;
        end
      end
      // pass is judged on the values this final response produces
      if (last) begin
        state <= DONE;
        bus.pass <= (err_next == 8'd0) && (sig_next == bus.golden_sig);
      end
    end
  end
endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb_bist_response_analyzer: directed sessions against a cycle-level behavioural model
module tb_bist_response_analyzer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bist_response_analyzer_if #(.SIG_WIDTH(8)) bus ();
  bist_response_analyzer #(.NUM_PATTERNS(8), .SIG_WIDTH(8), .SIG_SEED(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  bit m_run = 0, m_done = 0, m_pass = 0, m_fs = 0;
  int m_err = 0, m_cnt = 0;
  logic [7:0] m_map = 8'h00, m_sig = 8'h00;
  logic [2:0] m_ff = 3'd0;

  function automatic logic [1:0] fa(input logic [2:0] p);
    logic [1:0] t;
    t = {1'b0, p[2]} + {1'b0, p[1]} + {1'b0, p[0]};
    return {t[0], t[1]};
  endfunction

  function automatic logic [7:0] misr(input logic [7:0] s, input logic [1:0] r);
    logic [8:0] v;
    v = {s, 1'b0} ^ {7'd0, r};
    if (v[8]) v = v ^ 9'h11D;
    return v[7:0];
  endfunction

  function automatic logic [1:0] fault_resp(input int mode, input logic [2:0] p);
    logic [1:0] r;
    r = fa(p);
    if (mode == 1) return {1'b1, r[0]};
    if (mode == 2) return fa({1'b0, p[1:0]});
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_pass = 0; m_fs = 0;
      m_err = 0; m_cnt = 0; m_map = 8'h00; m_sig = 8'h00; m_ff = 3'd0;
    end else if (bus.start && !m_run) begin
      m_run = 1; m_done = 0; m_pass = 0; m_fs = 0;
      m_err = 0; m_cnt = 0; m_map = 8'h00; m_sig = 8'h00; m_ff = 3'd0;
    end else if (m_run && bus.pat_valid) begin
      if (bus.resp != fa(bus.pat)) begin
        if (m_err < 255) m_err++;
        m_map[bus.pat] = 1'b1;
        if (!m_fs) begin m_ff = bus.pat; m_fs = 1; end
      end
      m_sig = misr(m_sig, bus.resp);
      m_cnt++;
      if (m_cnt == 8) begin
        m_run = 0; m_done = 1;
        m_pass = (m_err == 0) && (m_sig == bus.golden_sig);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("pass", 32'(bus.pass), 32'(m_pass));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
    chk("first_fail", 32'(bus.first_fail), 32'(m_ff));
    chk("fail_seen", 32'(bus.fail_seen), 32'(m_fs));
    chk("fail_map", 32'(bus.fail_map), 32'(m_map));
    chk("signature", 32'(bus.signature), 32'(m_sig));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic session(input int mode, input logic [7:0] golden, input bit gapped);
    bus.golden_sig = golden;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.pat = k[2:0];
      bus.resp = fault_resp(mode, k[2:0]);
      bus.pat_valid = 1'b1;
      tick;
      if (gapped && k < 7) begin
        bus.pat_valid = 1'b0;
        bus.start = (k == 3);
        bus.pat = 3'd7;
        bus.resp = 2'd0;
        tick;
        bus.start = 1'b0;
      end
    end
    chk("done_after_8th", 32'(bus.done), 32'd1);
    bus.pat = 3'd0;
    bus.resp = 2'd3;
    tick;
    bus.pat_valid = 1'b0;
    tick;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pat_valid = 1'b1;
    bus.pat = 3'd5;
    bus.resp = 2'd0;
    bus.golden_sig = 8'h00;
    tick; tick;
    rst_n = 1'b1;
    tick; tick;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_sig", 32'(bus.signature), 32'h00);
    bus.pat_valid = 1'b0;
    session(0, 8'hC5, 0);
    chk("ff_model_sig", 32'(m_sig), 32'hC5);
    chk("ff_sig", 32'(bus.signature), 32'hC5);
    chk("ff_pass", 32'(bus.pass), 32'd1);
    chk("ff_err", 32'(bus.err_cnt), 32'd0);
    chk("ff_map", 32'(bus.fail_map), 32'h00);
    chk("ff_seen", 32'(bus.fail_seen), 32'd0);
    session(1, 8'hF4, 0);
    chk("sa1_model_sig", 32'(m_sig), 32'hF4);
    chk("sa1_err", 32'(bus.err_cnt), 32'd4);
    chk("sa1_map", 32'(bus.fail_map), 32'h69);
    chk("sa1_first", 32'(bus.first_fail), 32'd0);
    chk("sa1_pass", 32'(bus.pass), 32'd0);
    session(2, 8'h00, 0);
    chk("a0_err", 32'(bus.err_cnt), 32'd4);
    chk("a0_map", 32'(bus.fail_map), 32'hF0);
    chk("a0_first", 32'(bus.first_fail), 32'd4);
    chk("a0_pass", 32'(bus.pass), 32'd0);
    session(0, 8'hC4, 0);
    chk("badgold_err", 32'(bus.err_cnt), 32'd0);
    chk("badgold_pass", 32'(bus.pass), 32'd0);
    chk("badgold_sig", 32'(bus.signature), 32'hC5);
    session(0, 8'hC5, 1);
    chk("gap_pass", 32'(bus.pass), 32'd1);
    chk("gap_sig", 32'(bus.signature), 32'hC5);
    chk("gap_err", 32'(bus.err_cnt), 32'd0);
    bus.golden_sig = 8'hC5;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.pat = k[2:0];
      bus.resp = fault_resp(1, k[2:0]);
      bus.pat_valid = 1'b1;
      tick;
    end
    bus.pat_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err_cnt), 32'd0);
    chk("rst_map", 32'(bus.fail_map), 32'h00);
    chk("rst_sig", 32'(bus.signature), 32'h00);
    chk("rst_seen", 32'(bus.fail_seen), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    session(0, 8'hC5, 0);
    chk("post_rst_pass", 32'(bus.pass), 32'd1);
    chk("post_rst_err", 32'(bus.err_cnt), 32'd0);
    chk("post_rst_map", 32'(bus.fail_map), 32'h00);
    chk("post_rst_sig", 32'(bus.signature), 32'hC5);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
